rca_ou_lsq: RTL and testbench
=============================

Name: rca_ou_lsq

Overview:
Per-operation-unit load/store queue for the reconfigurable accelerator (RCA).
- Accepts load/store requests from one RCA load/store operation unit (load byte/half/word, store variants).
- Buffers requests in order, issues them to a word-wide data-memory port, and tracks outstanding loads.
- Returns aligned, sign/zero-extended load data to the operation unit.

Parameters:
- REQ_DEPTH, 4: request FIFO entries (power of two, ≥2).
- MAX_OUTSTANDING, 4: maximum in-flight loads awaiting mem_rvalid (power of two, ≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- addr  in  XLEN  byte address from the operation unit.
- data  in  XLEN  store data, low-aligned.
- fn3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW).
- load  in  1  request is a load.
- store  in  1  request is a store.
- new_request  in  1  request valid; accepted iff !lsq_full.
- lsq_full  out  1  request FIFO full.
- load_data  out  XLEN  extended load result.
- load_complete  out  1  single-cycle pulse, load_data valid.
- lsq_idle  out  1  FIFO empty and no loads outstanding.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}.
- mem_we  out  1  1 = store, 0 = load.
- mem_be  out  4  byte enables.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_rdata  in  XLEN  load return word.
- mem_rvalid  in  1  load return valid, in issue order.

Behaviour:
- Reset:
  - FIFO and tracker pointers/counts cleared.
  - Outputs: lsq_full=0, load_complete=0, load_data=0, mem_req_valid=0, lsq_idle=1.
  - Reset mid-operation discards queued and outstanding requests. The memory side shares the reset, so no stale returns arrive.
- Push:
  - Condition: new_request && !lsq_full. Stores {addr, data, fn3, load}.
  - lsq_full is decoded from the registered count only, so a same-cycle pop does not admit a push when full.
  - new_request while full is dropped; the operation unit guarantees it holds the request.
  - load and store both set, or both clear: entry is still queued, treated as store iff store=1.
- Issue:
  - mem_req_valid = FIFO non-empty && (head is store || outstanding < MAX_OUTSTANDING).
  - Head driven combinationally from FIFO storage; earliest issue is the cycle after push.
  - Pop on mem_req_valid && mem_req_ready. Strict program order; no reordering or forwarding.
  - Stores are posted: the handshake completes them and no response is expected.
- Byte enables, from fn3[1:0] and off=addr[1:0]:
  - Byte: 4'b0001<<off.
  - Half: 4'b0011<<off.
  - Word: 4'b1111.
- Store data: mem_wdata replicates data[7:0] ×4 for bytes, data[15:0] ×2 for halves, data unchanged for words.
- Tracker:
  - On load issue, push {fn3, off} into the MAX_OUTSTANDING-entry FIFO.
  - On mem_rvalid, pop the tracker head. Issue and return in the same cycle keep the count unchanged.
- Load result:
  - Compute shifted = mem_rdata >> (off*8).
  - Extend per fn3: LB sign-extends bits[7], LBU zero-extends byte, LH sign-extends bits[15], LHU zero-extends half, LW uses full word.
  - Registered: load_data and load_complete asserted exactly 1 cycle after mem_rvalid.
  - load_data holds its value until the next completion.
- mem_rvalid with tracker empty: ignored, counts unchanged; simulation assertion fires.
- lsq_idle = FIFO count==0 && outstanding==0 (registered-state decode).

Optional Feature:
- Macro: RCA_LSQ_MISALIGN_CHECK_EN.
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]≠0, is flagged at push.
  - Flagged loads are never issued to memory; they complete with load_data=0 and load_complete, in order, when they reach the head and the tracker is empty.
  - Flagged stores are dropped at the head.
  - Extra output misalign_err (1 bit) pulses on each flagged entry as it leaves the FIFO. Reset 0.
- Undefined: no check, no misalign_err port. Misaligned accesses use the shifted lanes; bytes beyond the word are lost.

Decomposition:
- rca_config package gains:
  - Typedef lsq_entry_t {addr, data, fn3, is_load}.
  - Typedef load_track_t {fn3, offset}.
  - Constants REQ_DEPTH/MAX_OUTSTANDING defaults.
- funct3 constants (LS_B/H/W, LBU/LHU) come from taiga_config/riscv_types.
- One sub-module, rca_lsq_fifo: generic synchronous FIFO with count, full, empty, instantiated twice (request queue, load tracker).

Test Plan:
- LH addr=0x102, mem_rdata=0x8001_1234 → mem_be=4'b1100, mem_addr=0x100; load_complete one cycle after rvalid, load_data=0xFFFF_8001.
- Four pushes with mem_req_ready=0, REQ_DEPTH=4 → lsq_full=1 after 4th push; 5th new_request dropped. Release ready → 4 issues in order, lsq_full deasserts.
- SB addr=0x203 data=0xAB → mem_we=1, mem_be=4'b1000, mem_wdata=0xABAB_ABAB; no load_complete; lsq_idle=1 after handshake.
- MAX_OUTSTANDING=4, 5 loads, rvalid withheld → exactly 4 issued, 5th stalls. One rvalid → 5th issues same cycle as count drops.
- LBU addr=0x1 with mem_rvalid in the same cycle as a new load issue → tracker count steady, load_data=zero-extended byte1.
- rst asserted with 2 queued, 1 outstanding → next cycle lsq_idle=1, mem_req_valid=0, load_complete=0. With RCA_LSQ_MISALIGN_CHECK_EN: LW addr=0x2 → misalign_err pulse, load_data=0, no memory request.

Source files
------------

// File: rtl/rca_ou_lsq_pkg.sv
// Shared types and helpers for the RCA operation-unit load/store queue.
// Funct3 encodings mirror the RISC-V load/store opcodes.
package rca_ou_lsq_pkg;

  localparam int XLEN                = 32;
  localparam int REQ_DEPTH_DEF       = 4;
  localparam int MAX_OUTSTANDING_DEF = 4;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] L_BU  = 3'b100;
  localparam logic [2:0] L_HU  = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            is_load;
  } lsq_entry_t;

  typedef struct packed {
    logic [2:0] fn3;
    logic [1:0] offset;
  } load_track_t;

  function automatic logic [3:0] byte_en(input logic [2:0] fn3, input logic [1:0] off);
    case (fn3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] fn3, input logic [XLEN-1:0] d);
    case (fn3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [2:0] fn3,
                                                  input logic [1:0] off);
    logic [XLEN-1:0] s;
    s = word >> {off, 3'b000};
    case (fn3)
      LS_B:    return {{24{s[7]}}, s[7:0]};
      L_BU:    return {24'b0, s[7:0]};
      LS_H:    return {{16{s[15]}}, s[15:0]};
      L_HU:    return {16'b0, s[15:0]};
      default: return s;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] fn3, input logic [1:0] off);
    case (fn3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rca_ou_lsq_fifo.sv
// Generic synchronous FIFO with occupancy count; push when full and pop when empty are ignored.
// Head entry is read combinationally from storage.
module rca_lsq_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         wr_dat,
  input  logic                     pop,
  output T                         rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/rca_ou_lsq.sv
// In-order load/store queue between one RCA load/store unit and a word-wide data port.
// Define RCA_LSQ_MISALIGN_CHECK_EN to retire misaligned accesses locally with misalign_err.
module rca_ou_lsq
  import rca_ou_lsq_pkg::*;
#(
  parameter int REQ_DEPTH       = REQ_DEPTH_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      fn3,
  input  logic            load,
  input  logic            store,
  input  logic            new_request,
  output logic            lsq_full,
  output logic [XLEN-1:0] load_data,
  output logic            load_complete,
  output logic            lsq_idle,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);

  lsq_entry_t                    req_in;
  lsq_entry_t                    req_head;
  logic [$clog2(REQ_DEPTH):0]    req_count;
  logic                          req_full;
  logic                          req_empty;
  logic                          req_pop;

  load_track_t                   trk_in;
  load_track_t                   trk_head;
  logic [$clog2(MAX_OUTSTANDING):0] trk_count;
  logic                          trk_full;
  logic                          trk_empty;
  logic                          trk_push;

  logic [1:0]                    head_off;
  logic                          head_mis;
  logic                          mis_pop;
  logic                          mis_load;
  logic                          issue;
  logic                          ret_vld;

  // Both or neither of load/store set: store wins only when store is asserted.
  assign req_in = '{addr: addr, data: data, fn3: fn3, is_load: !store};

  rca_lsq_fifo #(.DEPTH(REQ_DEPTH), .T(lsq_entry_t)) u_req_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (new_request),
    .wr_dat (req_in),
    .pop    (req_pop),
    .rd_dat (req_head),
    .count  (req_count),
    .full   (req_full),
    .empty  (req_empty)
  );

  assign head_off = req_head.addr[1:0];

`ifdef RCA_LSQ_MISALIGN_CHECK_EN
  assign head_mis = misaligned(req_head.fn3, head_off);
`else
  assign head_mis = 1'b0;
`endif

  // A load may issue only while the tracker has room for its return.
  assign mem_req_valid = !req_empty && !head_mis && (!req_head.is_load || !trk_full);
  assign issue         = mem_req_valid && mem_req_ready;
  // Flagged loads wait for older returns so completions stay in order.
  assign mis_pop       = !req_empty && head_mis && (!req_head.is_load || trk_empty);
  assign mis_load      = mis_pop && req_head.is_load;
  assign req_pop       = issue || mis_pop;

  assign mem_addr  = {req_head.addr[XLEN-1:2], 2'b00};
  assign mem_we    = !req_head.is_load;
  assign mem_be    = byte_en(req_head.fn3, head_off);
  assign mem_wdata = store_lanes(req_head.fn3, req_head.data);

  assign trk_in   = '{fn3: req_head.fn3, offset: head_off};
  assign trk_push = issue && req_head.is_load;
  assign ret_vld  = mem_rvalid && !trk_empty;

  rca_lsq_fifo #(.DEPTH(MAX_OUTSTANDING), .T(load_track_t)) u_trk_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (trk_push),
    .wr_dat (trk_in),
    .pop    (mem_rvalid),
    .rd_dat (trk_head),
    .count  (trk_count),
    .full   (trk_full),
    .empty  (trk_empty)
  );

  assign lsq_full = req_full;
  assign lsq_idle = (req_count == '0) && (trk_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      load_complete <= 1'b0;
      load_data     <= '0;
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
      misalign_err  <= 1'b0;
`endif
    end else begin
      load_complete <= ret_vld || mis_load;
      if (ret_vld)
        load_data <= load_extend(mem_rdata, trk_head.fn3, trk_head.offset);
      else if (mis_load)
        load_data <= '0;
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
      misalign_err  <= mis_pop;
`endif
    end
  end

  // The memory side must never return data that was not requested.
  a_no_stray_return : assert property (@(posedge clk) disable iff (rst) mem_rvalid |-> !trk_empty);

endmodule

// File: tb/tb_rca_ou_lsq.sv
// Directed and randomized bench for rca_ou_lsq against a queue-based reference model.
module tb_rca_ou_lsq;

  localparam int DEPTH = 4;
  localparam int MAXO  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, data, load_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  fn3;
  logic        load, store, new_request, lsq_full, load_complete, lsq_idle;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
  logic [3:0]  mem_be;
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  rca_ou_lsq dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .data          (data),
    .fn3           (fn3),
    .load          (load),
    .store         (store),
    .new_request   (new_request),
    .lsq_full      (lsq_full),
    .load_data     (load_data),
    .load_complete (load_complete),
    .lsq_idle      (lsq_idle),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid)
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    bit          is_load;
  } req_t;

  typedef struct {
    logic [2:0] f;
    int         off;
  } trk_t;

  req_t        req_q[$];
  trk_t        pend_q[$];
  logic [31:0] exp_ld;
  logic [31:0] last_ld;
  bit          cmp_due;
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, act, exp);
  endtask

  function automatic logic [3:0] ref_be(input logic [2:0] f, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    case (f % 4)
      0:       return 4'(1 << off);
      1:       return 4'(3 << off);
      default: return 4'hf;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f, input logic [31:0] d);
    case (f % 4)
      0:       return (d % 256) * 32'h0101_0101;
      1:       return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [2:0] f, input int off);
    logic [31:0] s;
    s = rd >> (8 * off);
    case (f)
      3'd0:    return 32'(int'(byte'(s[7:0])));
      3'd4:    return s % 256;
      3'd1:    return 32'(int'(shortint'(s[15:0])));
      3'd5:    return s % 65536;
      default: return s;
    endcase
  endfunction

  function automatic bit exp_valid();
    return req_q.size() > 0 && (!req_q[0].is_load || pend_q.size() < MAXO);
  endfunction

  task automatic check_state();
    bit v;
    v = exp_valid();
    chk("req_valid", {31'b0, mem_req_valid}, {31'b0, v});
    if (v) begin
      chk("mem_addr", mem_addr, req_q[0].a & 32'hffff_fffc);
      chk("mem_we", {31'b0, mem_we}, {31'b0, !req_q[0].is_load});
      chk("mem_be", {28'b0, mem_be}, {28'b0, ref_be(req_q[0].f, req_q[0].a)});
      if (!req_q[0].is_load) chk("mem_wdata", mem_wdata, ref_wdata(req_q[0].f, req_q[0].d));
    end
    chk("lsq_full", {31'b0, lsq_full}, {31'b0, req_q.size() == DEPTH});
    chk("lsq_idle", {31'b0, lsq_idle}, {31'b0, req_q.size() == 0 && pend_q.size() == 0});
    chk("load_complete", {31'b0, load_complete}, {31'b0, cmp_due});
    if (cmp_due) last_ld = exp_ld;
    chk("load_data", load_data, last_ld);
  endtask

  // Drives one cycle of inputs, advances the model, then checks at the next falling edge.
  task automatic tick(input bit req, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                      input bit ld, input bit st, input bit rdy, input bit rv, input logic [31:0] rd);
    bit   v;
    bit   was_full;
    bit   rv_ok;
    req_t e;
    trk_t t;
    v        = exp_valid();
    was_full = req_q.size() == DEPTH;
    rv_ok    = rv && pend_q.size() > 0;
    new_request   = req;
    addr          = a;
    data          = d;
    fn3           = f;
    load          = ld;
    store         = st;
    mem_req_ready = rdy;
    mem_rvalid    = rv_ok;
    mem_rdata     = rd;
    cmp_due       = rv_ok;
    if (rv_ok) begin
      t = pend_q.pop_front();
      exp_ld = ref_load(rd, t.f, t.off);
    end
    if (v && rdy) begin
      e = req_q.pop_front();
      if (e.is_load) pend_q.push_back('{f: e.f, off: int'(e.a % 4)});
    end
    if (req && !was_full) req_q.push_back('{a: a, d: d, f: f, is_load: !st});
    @(negedge clk);
    check_state();
  endtask

  task automatic idle_tick(input bit rdy, input bit rv, input logic [31:0] rd);
    tick(0, 32'h0, 32'h0, 3'd0, 0, 0, rdy, rv, rd);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (req_q.size() > 0 || pend_q.size() > 0); i++)
      idle_tick(1, 1, $urandom);
    chk("drain_idle", {31'b0, lsq_idle}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    new_request = 0; addr = 0; data = 0; fn3 = 0; load = 0; store = 0;
    mem_req_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    @(negedge clk);
    rst = 1'b0;
    req_q.delete();
    pend_q.delete();
    cmp_due = 0;
    last_ld = 32'h0;
    check_state();
  endtask

  initial begin
    logic [2:0] ftab [5];
    bit         st;
    ftab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // LH at offset 2 with a negative half.
    tick(1, 32'h102, 32'h0, 3'd1, 1, 0, 0, 0, 32'h0);
    chk("lh_be", {28'b0, mem_be}, 32'hc);
    chk("lh_addr", mem_addr, 32'h100);
    idle_tick(1, 0, 32'h0);
    idle_tick(0, 1, 32'h8001_1234);
    chk("lh_data", load_data, 32'hffff_8001);
    idle_tick(0, 0, 32'h0);

    // Fill the request queue while memory stalls; fifth request is dropped.
    for (int i = 0; i < 5; i++) begin
      tick(1, 32'h40 + 4 * i, 32'h1000 + i, 3'd2, 0, 1, 0, 0, 32'h0);
      if (i == 3) chk("full_after_4", {31'b0, lsq_full}, 32'd1);
    end
    drain();

    // Byte store at offset 3.
    tick(1, 32'h203, 32'hab, 3'd0, 0, 1, 0, 0, 32'h0);
    chk("sb_be", {28'b0, mem_be}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'habab_abab);
    chk("sb_we", {31'b0, mem_we}, 32'd1);
    idle_tick(1, 0, 32'h0);
    chk("sb_idle", {31'b0, lsq_idle}, 32'd1);
    chk("sb_no_complete", {31'b0, load_complete}, 32'd0);

    // Outstanding limit: fifth load waits for a return.
    for (int i = 0; i < 5; i++) tick(1, 32'h300 + 4 * i, 32'h0, 3'd2, 1, 0, 1, 0, 32'h0);
    chk("stall_5th", {31'b0, mem_req_valid}, 32'd0);
    idle_tick(1, 1, 32'h1111_2222);
    chk("issue_5th", {31'b0, mem_req_valid}, 32'd1);
    drain();

    // LBU return coinciding with a new load issue.
    tick(1, 32'h1, 32'h0, 3'd4, 1, 0, 0, 0, 32'h0);
    tick(1, 32'h8, 32'h0, 3'd2, 1, 0, 1, 0, 32'h0);
    tick(0, 32'h0, 32'h0, 3'd0, 0, 0, 1, 1, 32'h0000_c300);
    chk("lbu_data", load_data, 32'h0000_00c3);
    chk("lbu_busy", {31'b0, lsq_idle}, 32'd0);
    drain();

    // Reset with two queued stores and one outstanding load.
    tick(1, 32'h10, 32'h0, 3'd2, 1, 0, 0, 0, 32'h0);
    tick(1, 32'h20, 32'h5, 3'd2, 0, 1, 1, 0, 32'h0);
    tick(1, 32'h24, 32'h6, 3'd2, 0, 1, 0, 0, 32'h0);
    do_reset();
    chk("rst_idle", {31'b0, lsq_idle}, 32'd1);
    chk("rst_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_complete", {31'b0, load_complete}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom % 2) == 1;
      tick(($urandom % 3) != 0, $urandom, $urandom, st ? ftab[$urandom % 3] : ftab[$urandom % 5],
           ($urandom % 2) == 1, st, ($urandom % 4) != 0, ($urandom % 3) == 0, $urandom);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
